// File: rtl/mux_n_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mux_n_pipe : registered N-way mux with a two-entry valid/ready skid buffer |
// | Revision 1.0                                                             |
// +------------------------------------------------------------------------+
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [NUM_IN*WIDTH-1:0] iData,
  input  logic [SEL_W-1:0]        iSel,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic                    iFlush,
  output logic [WIDTH-1:0]        oData,
  output logic                    oValid,
  input  logic                    iReady
);

  // State is the (main_v, skid_v) occupancy pair.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             r_main_v;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] r_skid_d;
  logic [WIDTH-1:0] w_sel_data;
  logic [1:0]       w_state;
  logic             w_accept;
  logic             w_consume;

  // Selects with no matching input (iSel >= NUM_IN) fall through to zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (iSel == SEL_W'(k)) begin
        w_sel_data = iData[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_state   = {r_main_v, r_skid_v};
  assign w_accept  = iValid && !r_skid_v;
  assign w_consume = r_main_v && iReady;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (iFlush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_d <= w_sel_data;
            r_main_v <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            r_main_d <= w_sel_data;
          end else if (w_accept) begin
            r_skid_d <= w_sel_data;
            r_skid_v <= 1'b1;
          end else if (w_consume) begin
            r_main_v <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_consume) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign oReady = !r_skid_v;
  assign oValid = r_main_v;
  assign oData  = r_main_d;

endmodule
`default_nettype wire
